dct_transpose_buffer: RTL and testbench
=======================================

# dct_transpose_buffer

Transpose buffer for the 2-D IntDCT, placed between the row pass and the column pass. It accepts DIM row vectors from the row-pass transform over a valid/ready handshake and stores a full DIM×DIM block. It then emits the block column by column, so each emitted vector can feed the column-pass butterfly input add stage directly. Operation is single-bank and half-duplex: fill the block, then drain it.

## Interface
- WIDTH, 16, signed sample width at input and output (no growth)
- DIM, 8, block dimension; power of two, ≥2
- HCLK  in  1  clock, all state updates on rising edge
- HRESETn  in  1  reset, synchronous, active-low
- flush  in  1  synchronous abort: discard partial block and return to fill
- in_valid  in  1  in_row holds a valid row
- in_ready  out  1  buffer accepts a row this cycle
- in_row  in  signed [WIDTH-1:0] ×[DIM]  row vector, element i = column i
- out_valid  out  1  out_col holds a valid column
- out_ready  in  1  consumer accepts the column this cycle
- out_col  out  signed [WIDTH-1:0] ×[DIM]  column vector, element i = row i
- out_last  out  1  high with out_valid on the final column (c = DIM-1) of a block

## Operation
- Storage: mem[r][c], DIM×DIM registers of WIDTH bits. Counters row_cnt and col_cnt are each $clog2(DIM) bits.
- States: FILL and DRAIN.
- In FILL, in_ready=1 and out_valid=0.
  - When in_valid && in_ready, write mem[row_cnt][i] = in_row[i] for all i, then increment row_cnt.
  - Accepting the row with row_cnt == DIM-1 sets row_cnt to 0 and moves to DRAIN.
- In DRAIN, in_ready=0 and out_valid=1.
  - out_col[i] = mem[i][col_cnt].
  - out_last = (col_cnt == DIM-1).
  - When out_valid && out_ready, increment col_cnt.
  - Accepting the column with col_cnt == DIM-1 sets col_cnt to 0 and moves to FILL.
- No arithmetic is performed. Values pass bit-exact and the sign is preserved.
- flush: the state goes to FILL and both counters clear in the next cycle. flush has priority over any handshake in the same cycle; the row or column offered that cycle is not accepted, even if in_ready or out_valid is high. mem is not cleared.
- Reset (HRESETn=0 at an edge), after that edge:
  - state = FILL, row_cnt = col_cnt = 0
  - in_ready = 1, out_valid = 0, out_last = 0
  - all mem = 0, so out_col reads 0
- Reset has priority over flush and over handshakes. Reset mid-block discards the block.
- in_valid while in_ready = 0 is ignored; the producer holds its data. out_ready while out_valid = 0 is ignored.

## Timing
- in_ready, out_valid and out_last are derived from registered state and counters only. There is no combinational path from in_valid or out_ready to any output.
- Latency: last row accepted at edge N gives out_valid = 1 and out_col = column 0 in the cycle after edge N.
- Last column accepted at edge M gives in_ready = 1 in the cycle after edge M.
- Minimum block period is 2·DIM cycles with full-rate handshakes.
- While out_valid && !out_ready, out_col and out_last stay stable.
- Rows are written on the edge that completes the handshake. Data on in_row in other cycles has no effect.

## Structure
- The shared IntDCT package holds:
  - the state typedef: enum logic {TB_FILL, TB_DRAIN}
  - the default WIDTH and DIM constants, so the row pass, this buffer and the column pass agree
- Single module; no sub-module required. The column read mux is a for-loop over rows indexed by col_cnt.
- Elaboration assertion: DIM is a power of two and DIM ≥ 2.

## Test plan
- Reset: hold HRESETn=0 for 3 cycles with in_valid=1 → after release, in_ready=1, out_valid=0, out_last=0, all out_col=0, and no row was stored.
- Full block: in_row[i] = 8r+i for r = 0..7 back-to-back, out_ready=1.
  - out_valid rises the cycle after the 8th accept.
  - Column c gives out_col[i] = 8i+c.
  - out_last is high only for c = 7.
  - in_ready returns the cycle after column 7.
- Backpressure: during DRAIN, out_ready = 1,0,0,1,… → column advances only on handshake cycles, out_col stays stable when stalled, and in_ready stays 0 for the whole drain.
- Gapped input: in_valid pseudo-random (~50%) with changing in_row on invalid cycles → only the 8 handshaked rows appear, transposed, at the output.
- Flush: flush after 5 rows, in the same cycle as in_valid=1, then send a fresh 8-row block → the flushed-cycle row is not stored and the output holds only the fresh block. A flush mid-DRAIN → the next output appears only after 8 new rows.
- Extremes and back-to-back: alternate -32768 and 32767 across a block, then immediately a second block → values pass bit-exact, and the second block's first row is accepted the cycle after the first block's out_last handshake.

Source files
------------

// File: rtl/dct_transpose_buffer_pkg.sv
// Shared IntDCT definitions used by the row pass, this transpose buffer and
// the column pass, so that all three agree on sample width and block size.
//   TB_WIDTH   : default signed sample width
//   TB_DIM     : default block dimension (power of two, >= 2)
//   tb_state_e : transpose buffer state (fill rows / drain columns)
package dct_transpose_buffer_pkg;

  localparam int TB_WIDTH = 16;
  localparam int TB_DIM   = 8;

  typedef enum logic {
    TB_FILL  = 1'b0,
    TB_DRAIN = 1'b1
  } tb_state_e;

endpackage

// File: rtl/dct_transpose_buffer_if.sv
// Row-in / column-out bus of the IntDCT transpose buffer.
//   flush     : synchronous abort of the current block
//   in_valid  : in_row holds a row        in_ready  : buffer takes a row
//   in_row    : row vector, element i = column i
//   out_valid : out_col holds a column    out_ready : consumer takes it
//   out_col   : column vector, element i = row i
//   out_last  : final column of the block
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high (and flush is low). The sender holds valid and data stable until
// that edge; ready never depends combinationally on valid.
// master = producer/consumer side, slave = the buffer.
interface dct_transpose_buffer_if
  import dct_transpose_buffer_pkg::*;
#(
  parameter int WIDTH = TB_WIDTH,
  parameter int DIM   = TB_DIM
);

  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_row  [DIM];
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_col [DIM];
  logic                    out_last;

  modport master (
    output flush, in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_col, out_last
  );

  modport slave (
    input  flush, in_valid, in_row, out_ready,
    output in_ready, out_valid, out_col, out_last
  );

endinterface

// File: rtl/dct_transpose_buffer.sv
// Transpose buffer between the IntDCT row pass and column pass. Collects DIM
// rows into a DIM x DIM register block, then emits it column by column.
// Single bank, half duplex: the block is completely filled, then drained.
// Ports:
//   HCLK      : clock, rising edge
//   HRESETn   : synchronous active-low reset (clears state, counters, storage)
//   bus       : slave side of dct_transpose_buffer_if (rows in, columns out)
//   dbg_state : current FSM state, for observation only
module dct_transpose_buffer
  import dct_transpose_buffer_pkg::*;
#(
  parameter int WIDTH = TB_WIDTH,
  parameter int DIM   = TB_DIM
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  dct_transpose_buffer_if.slave  bus,
  output tb_state_e              dbg_state
);

  localparam int              CNT_W   = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIM - 1);

  generate
    if ((DIM < 2) || ((DIM & (DIM - 1)) != 0)) begin : g_dim_check
      $error("dct_transpose_buffer: DIM must be a power of two and >= 2");
    end
  endgenerate

  tb_state_e               state_q,   state_d;
  logic [CNT_W-1:0]        row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0]        col_cnt_q, col_cnt_d;
  logic signed [WIDTH-1:0] mem_q [DIM][DIM];
  logic signed [WIDTH-1:0] mem_d [DIM][DIM];

  // Next state, counters and row write. flush overrides any handshake offered
  // in the same cycle; storage is left untouched by flush.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    mem_d     = mem_q;

    if (bus.flush) begin
      state_d   = TB_FILL;
      row_cnt_d = '0;
      col_cnt_d = '0;
    end else begin
      case (state_q)
        TB_FILL: begin
          if (bus.in_valid) begin
            for (int i = 0; i < DIM; i++) begin
              mem_d[row_cnt_q][i] = bus.in_row[i];
            end
            if (row_cnt_q == CNT_MAX) begin
              row_cnt_d = '0;
              state_d   = TB_DRAIN;
            end else begin
              row_cnt_d = row_cnt_q + CNT_W'(1);
            end
          end
        end
        TB_DRAIN: begin
          if (bus.out_ready) begin
            if (col_cnt_q == CNT_MAX) begin
              col_cnt_d = '0;
              state_d   = TB_FILL;
            end else begin
              col_cnt_d = col_cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = TB_FILL;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q   <= TB_FILL;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      mem_q     <= mem_d;
    end
  end

  // All handshake outputs come from registered state only.
  assign bus.in_ready  = (state_q == TB_FILL);
  assign bus.out_valid = (state_q == TB_DRAIN);
  assign bus.out_last  = (state_q == TB_DRAIN) && (col_cnt_q == CNT_MAX);
  assign dbg_state     = state_q;

  // Column read mux: element i of the output is row i of the selected column.
  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      bus.out_col[i] = mem_q[i][col_cnt_q];
    end
  end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
module tb_dct_transpose_buffer;
  import dct_transpose_buffer_pkg::*;

  localparam int WIDTH = TB_WIDTH;
  localparam int DIM   = TB_DIM;
  localparam int RW    = WIDTH * DIM;
  localparam int W     = RW + 1;      // column data plus last flag in bit RW
  localparam int BOUND = 2000;

  typedef logic [RW-1:0] row_t;

  typedef struct {
    int in_pct;
    int out_pct;
    int pattern;     // 0 random, 1 extremes, 2 DIM*r+i
    int n_rows;
    int exp_blocks;  // out_last handshakes expected
  } scen_t;

  // ---------------- clock / reset ----------------
  logic      HCLK    = 1'b0;
  logic      HRESETn = 1'b0;
  tb_state_e dbg_state;

  always #5 HCLK = ~HCLK;

  dct_transpose_buffer_if #(.WIDTH(WIDTH), .DIM(DIM)) bus ();

  dct_transpose_buffer #(.WIDTH(WIDTH), .DIM(DIM)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  // row_q: rows accepted into the current block. When it holds DIM rows the
  // transposed columns are pushed to exp_q; a non-empty exp_q means the
  // buffer must be draining, and its head is the column it must show.
  logic [W-1:0] exp_q [$];
  row_t         row_q [$];
  int           n_checks = 0;
  int           n_pass   = 0;
  scen_t        scen_tab [6];

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check_col(input string name, input row_t act, input row_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic row_t get_out_col();
    row_t v;
    for (int i = 0; i < DIM; i++) v[i*WIDTH +: WIDTH] = bus.out_col[i];
    return v;
  endfunction

  function automatic row_t rand_row();
    row_t v;
    for (int i = 0; i < DIM; i++) v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    return v;
  endfunction

  function automatic row_t gen_row(input int pattern, input int r);
    row_t v;
    for (int i = 0; i < DIM; i++) begin
      case (pattern)
        1:       v[i*WIDTH +: WIDTH] = (((r + i) % 2) == 0) ? 16'h8000 : 16'h7fff;
        2:       v[i*WIDTH +: WIDTH] = WIDTH'(DIM * r + i);
        default: v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      endcase
    end
    return v;
  endfunction

  function automatic void model_complete_block();
    logic [W-1:0] col;
    row_t         rr;
    for (int c = 0; c < DIM; c++) begin
      col = '0;
      for (int i = 0; i < DIM; i++) begin
        rr = row_q[i];
        col[i*WIDTH +: WIDTH] = rr[c*WIDTH +: WIDTH];
      end
      col[RW] = (c == DIM - 1);
      exp_q.push_back(col);
    end
    row_q.delete();
  endfunction

  task automatic check_outputs();
    logic exp_drain;
    exp_drain = (exp_q.size() != 0);
    check1("in_ready", bus.in_ready, !exp_drain);
    check1("out_valid", bus.out_valid, exp_drain);
    check1("dbg_state", dbg_state == TB_DRAIN, exp_drain);
    if (exp_drain) begin
      check_col("out_col", get_out_col(), exp_q[0][RW-1:0]);
      check1("out_last", bus.out_last, exp_q[0][RW]);
    end else begin
      check1("out_last_idle", bus.out_last, 1'b0);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_row(input row_t row);
    for (int i = 0; i < DIM; i++) bus.in_row[i] = row[i*WIDTH +: WIDTH];
  endtask

  // One cycle: called at a falling edge, drives inputs, checks outputs, then
  // advances the model across the rising edge.
  task automatic step(input logic fl, input logic iv, input row_t row, input logic ordy);
    logic in_fire, out_fire;
    bus.flush     = fl;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    drive_row(row);
    check_outputs();
    in_fire  = iv && (exp_q.size() == 0) && !fl;
    out_fire = ordy && (exp_q.size() != 0) && !fl;
    @(posedge HCLK);
    if (fl) begin
      row_q.delete();
      exp_q.delete();
    end else begin
      if (out_fire) void'(exp_q.pop_front());
      if (in_fire) begin
        row_q.push_back(row);
        if (row_q.size() == DIM) model_complete_block();
      end
    end
    @(negedge HCLK);
  endtask

  task automatic do_reset();
    HRESETn       = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_row(rand_row());
      @(negedge HCLK);
    end
    HRESETn      = 1'b1;
    bus.in_valid = 1'b0;
    row_q.delete();
    exp_q.delete();
    check1("rst_in_ready", bus.in_ready, 1'b1);
    check1("rst_out_valid", bus.out_valid, 1'b0);
    check1("rst_out_last", bus.out_last, 1'b0);
    check1("rst_state_fill", dbg_state == TB_FILL, 1'b1);
    check_col("rst_out_col", get_out_col(), '0);
  endtask

  task automatic drain_all(input int out_pct);
    int k = 0;
    while (exp_q.size() != 0 && k < BOUND) begin
      step(1'b0, 1'b0, rand_row(), $urandom_range(1, 100) <= out_pct);
      k++;
    end
    check1("drain_done", exp_q.size() == 0, 1'b1);
  endtask

  task automatic run_scenario(input scen_t s);
    int   sent = 0;
    int   cyc = 0;
    int   blocks = 0;
    logic iv, ordy;
    row_t row;
    while ((sent < s.n_rows || exp_q.size() != 0) && cyc < BOUND) begin
      iv   = (sent < s.n_rows) && ($urandom_range(1, 100) <= s.in_pct);
      row  = iv ? gen_row(s.pattern, sent % DIM) : rand_row();
      ordy = ($urandom_range(1, 100) <= s.out_pct);
      if (bus.out_valid && bus.out_last && ordy) blocks++;
      if (iv && exp_q.size() == 0) sent++;
      step(1'b0, iv, row, ordy);
      cyc++;
    end
    check_int("scenario_blocks", blocks, s.exp_blocks);
    if (row_q.size() != 0) step(1'b1, 1'b0, rand_row(), 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    row_t prev;
    logic ordy;
    int   k;

    scen_tab[0] = '{100, 100, 2, 16, 2};  // sequential, full rate, back-to-back
    scen_tab[1] = '{ 50, 100, 0,  8, 1};  // gapped input
    scen_tab[2] = '{100, 100, 1, 16, 2};  // extremes, back-to-back blocks
    scen_tab[3] = '{ 50,  40, 0, 24, 3};  // gaps on both sides
    scen_tab[4] = '{100,  30, 1,  8, 1};  // heavy backpressure
    scen_tab[5] = '{ 70,  70, 0, 12, 1};  // trailing partial block flushed

    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_row('0);
    @(negedge HCLK);
    do_reset();

    run_scenario(scen_tab[0]);

    // Backpressure: out_ready = 1,0,0 repeating; column must hold while stalled.
    for (int r = 0; r < DIM; r++) step(1'b0, 1'b1, gen_row(2, r), 1'b0);
    k = 0;
    while (exp_q.size() != 0 && k < BOUND) begin
      ordy = ((k % 3) == 0);
      prev = get_out_col();
      step(1'b0, $urandom_range(0, 1) == 1, rand_row(), ordy);
      if (!ordy && bus.out_valid) check_col("stall_stable", get_out_col(), prev);
      k++;
    end
    check1("bp_drain_done", exp_q.size() == 0, 1'b1);

    // Flush after 5 rows, together with a valid row that must be dropped.
    for (int r = 0; r < 5; r++) step(1'b0, 1'b1, gen_row(0, r), 1'b0);
    step(1'b1, 1'b1, gen_row(0, 5), 1'b0);
    for (int r = 0; r < DIM; r++) step(1'b0, 1'b1, gen_row(2, r), 1'b0);
    drain_all(100);

    // Flush mid-drain: nothing comes out until a fresh DIM rows arrive.
    for (int r = 0; r < DIM; r++) step(1'b0, 1'b1, gen_row(0, r), 1'b1);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, rand_row(), 1'b1);
    step(1'b1, 1'b0, rand_row(), 1'b1);
    for (int r = 0; r < DIM - 1; r++) step(1'b0, 1'b1, gen_row(0, r), 1'b1);
    step(1'b0, 1'b0, rand_row(), 1'b1);
    step(1'b0, 1'b0, rand_row(), 1'b1);
    step(1'b0, 1'b1, gen_row(0, DIM - 1), 1'b1);
    drain_all(100);

    for (int s = 1; s < 6; s++) run_scenario(scen_tab[s]);

    // Reset in the middle of a drain clears storage and the block.
    for (int r = 0; r < DIM; r++) step(1'b0, 1'b1, gen_row(1, r), 1'b0);
    step(1'b0, 1'b0, rand_row(), 1'b1);
    step(1'b0, 1'b0, rand_row(), 1'b1);
    do_reset();
    run_scenario(scen_tab[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
